bcd_digit_entry: RTL

- Sequential front end that collects decimal digits one at a time into a right-justified packed BCD word.
- On commit, presents the word through a valid/ready handshake.
- Sits directly upstream of the combinational BCD-to-binary converter; bcd_out feeds its 16-bit bcd input.
- Supports backspace, clear, digit-range checking and overflow flagging; entry may continue while a committed word waits.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_entry_if.sv | 33 +++
 rtl/bcd_shift_reg.sv | 56 +++++
 rtl/bcd_digit_entry.sv | 117 +++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types, constants and digit check
package bcd_pkg;

    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic {
        ENTRY = 1'b0,
        HOLD  = 1'b1
    } entry_state_t;

    function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] d);
        return (d <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_entry_if.sv
// rtl/bcd_digit_entry_if.sv - keypad command and committed-word handshake bundle
interface bcd_digit_entry_if #(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = 3
);
    localparam int BCD_W = 4 * NUM_DIGITS;

    logic             digit_valid;
    logic [3:0]       digit;
    logic             backspace;
    logic             clear;
    logic             enter;
    logic [BCD_W-1:0] entry_bcd;
    logic [CNT_W-1:0] digit_count;
    logic [BCD_W-1:0] bcd_out;
    logic             bcd_valid;
    logic             bcd_ready;
    logic             err_digit;
    logic             overflow;

    // Keypad source / downstream sink side
    modport master (
        output digit_valid, digit, backspace, clear, enter, bcd_ready,
        input  entry_bcd, digit_count, bcd_out, bcd_valid, err_digit, overflow
    );

    // Entry block side
    modport slave (
        input  digit_valid, digit, backspace, clear, enter, bcd_ready,
        output entry_bcd, digit_count, bcd_out, bcd_valid, err_digit, overflow
    );

endinterface

// File: rtl/bcd_shift_reg.sv
// rtl/bcd_shift_reg.sv - right-justified BCD digit shift register with count
module bcd_shift_reg #(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = 3,
    parameter int BCD_W      = 4 * NUM_DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [3:0]       push_digit,
    input  logic             pop,
    input  logic             clr,
    output logic [BCD_W-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_DIGITS);

    logic [BCD_W-1:0] word_d, word_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign data  = word_q;
    assign count = cnt_q;

    // Next word/count: clear wins, then pop, then push; push/pop guarded by full/empty
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (pop && !empty) begin
            word_d = {4'h0, word_q[BCD_W-1:4]};
            cnt_d  = cnt_q - 1'b1;
        end else if (push && !full) begin
            word_d = {word_q[BCD_W-5:0], push_digit};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Register the entry word and digit count
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_digit_entry.sv
// rtl/bcd_digit_entry.sv - decimal digit entry front end with committed-word handshake
module bcd_digit_entry
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = 3
) (
    input logic                clk,
    input logic                rst,
    bcd_digit_entry_if.slave   bus
);

    localparam int BCD_W = 4 * NUM_DIGITS;

    logic             do_enter, do_bksp, do_digit, digit_ok, commit;
    logic             sr_full, sr_empty;
    logic [BCD_W-1:0] sr_data;
    logic [CNT_W-1:0] sr_count;

    entry_state_t     state_d, state_q;
    logic [BCD_W-1:0] bcd_out_d, bcd_out_q;
    logic             bcd_valid_d, bcd_valid_q;
    logic             err_d, err_q;
    logic             ovf_d, ovf_q;

    // One command per cycle: clear > enter > backspace > digit
    always_comb begin
        do_enter = !bus.clear && bus.enter;
        do_bksp  = !bus.clear && !bus.enter && bus.backspace;
        do_digit = !bus.clear && !bus.enter && !bus.backspace && bus.digit_valid;
        digit_ok = is_bcd_digit(bus.digit);
        // A commit is legal with a non-empty entry and either no word pending or the pending one leaving now
        commit   = do_enter && !sr_empty && (state_q == ENTRY || bus.bcd_ready);
    end

    bcd_shift_reg #(
        .NUM_DIGITS (NUM_DIGITS),
        .CNT_W      (CNT_W),
        .BCD_W      (BCD_W)
    ) u_shift_reg (
        .clk        (clk),
        .rst        (rst),
        .push       (do_digit && digit_ok),
        .push_digit (bus.digit),
        .pop        (do_bksp),
        .clr        (bus.clear || commit),
        .data       (sr_data),
        .count      (sr_count),
        .full       (sr_full),
        .empty      (sr_empty)
    );

    // Next-state for the handshake FSM and the sticky/pulse flags
    always_comb begin
        state_d     = state_q;
        bcd_out_d   = bcd_out_q;
        bcd_valid_d = bcd_valid_q;
        err_d       = err_q;
        ovf_d       = 1'b0;

        if (bus.clear)
            err_d = 1'b0;
        else if (do_digit && !digit_ok)
            err_d = 1'b1;

        if (do_digit && digit_ok && sr_full)
            ovf_d = 1'b1;

        case (state_q)
            ENTRY: begin
                if (commit) begin
                    bcd_out_d   = sr_data;
                    bcd_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (commit) begin
                    bcd_out_d   = sr_data;
                    bcd_valid_d = 1'b1;
                end else if (bus.bcd_ready) begin
                    bcd_valid_d = 1'b0;
                    state_d     = ENTRY;
                end
            end
            default: begin
                bcd_valid_d = 1'b0;
                state_d     = ENTRY;
            end
        endcase
    end

    // Handshake FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ENTRY;
            bcd_out_q   <= '0;
            bcd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd_out_q   <= bcd_out_d;
            bcd_valid_q <= bcd_valid_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.entry_bcd   = sr_data;
    assign bus.digit_count = sr_count;
    assign bus.bcd_out     = bcd_out_q;
    assign bus.bcd_valid   = bcd_valid_q;
    assign bus.err_digit   = err_q;
    assign bus.overflow    = ovf_q;

endmodule
